// File: rtl/mmio_txn_checker_pkg.sv
// Shared types for the MMIO transaction checker: tracker entry layout and access kinds.
package mmio_txn_checker_pkg;

  localparam int MAX_REGIONS  = 8;
  // Region index is sized for the largest supported region count so the entry layout never changes.
  localparam int REGION_IDX_W = 3;

  typedef enum logic {
    KIND_RD = 1'b0,
    KIND_WR = 1'b1
  } txn_kind_e;

  typedef struct packed {
    txn_kind_e                 kind;
    logic                      hit;
    logic [REGION_IDX_W-1:0]   region_idx;
    logic [31:0]               addr;
    logic [31:0]               exp;
  } txn_entry_t;

endpackage

// File: rtl/mmio_txn_checker_if.sv
// Core data-bus tap plus the same-cycle expected-data lookup used by the checker.
interface mmio_txn_checker_if;

  // Bus semantics: a request is d_rd_i with d_wr_i==0 (read) or any d_wr_i bit set (write),
  // presented for exactly one cycle; d_ack_i completes the oldest outstanding request, in order,
  // and d_data_rd_i is valid only in that ack cycle. exp_data_i answers exp_addr_o in the same cycle.
  logic [31:0] d_addr_i;
  logic        d_rd_i;
  logic [3:0]  d_wr_i;
  logic        d_ack_i;
  logic [31:0] d_data_rd_i;
  logic [31:0] exp_addr_o;
  logic [31:0] exp_data_i;

  modport master (
    output d_addr_i, d_rd_i, d_wr_i, d_ack_i, d_data_rd_i, exp_data_i,
    input  exp_addr_o
  );

  modport slave (
    input  d_addr_i, d_rd_i, d_wr_i, d_ack_i, d_data_rd_i, exp_data_i,
    output exp_addr_o
  );

endinterface

// File: rtl/mmio_txn_checker_fifo.sv
// In-order tracker of outstanding accesses; a push is accepted when full if a pop happens in the same cycle.
module mmio_txn_checker_fifo
  import mmio_txn_checker_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  txn_entry_t push_data,
  input  logic       pop,
  output txn_entry_t head,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  txn_entry_t  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // When full, the slot being written is the head being popped; the head is read before the edge.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mmio_txn_checker.sv
// MMIO read-data checker: tracks core data-bus accesses in order, checks read data against a lookup,
// and keeps saturating per-region read/write/error counters with a sticky done flag.
module mmio_txn_checker
  import mmio_txn_checker_pkg::*;
#(
  parameter int                         NUM_REGIONS   = 4,
  // Region 0 is the leftmost (most significant) 32-bit word of each list.
  parameter logic [NUM_REGIONS*32-1:0]  REGION_BASE   = {32'h8000_0000, 32'h8000_0020,
                                                         32'h8000_0100, 32'h8000_0200},
  parameter logic [NUM_REGIONS*32-1:0]  REGION_LAST   = {32'h8000_0014, 32'h8000_003C,
                                                         32'h8000_01FF, 32'h8000_02FF},
  parameter int                         OUTSTANDING   = 4,
  parameter int                         CNT_W         = 16,
  parameter int unsigned                TARGET_READS  = 2,
  parameter int unsigned                TARGET_WRITES = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  mmio_txn_checker_if.slave            bus,
  output logic [NUM_REGIONS*CNT_W-1:0] rd_cnt_o,
  output logic [NUM_REGIONS*CNT_W-1:0] wr_cnt_o,
  output logic [NUM_REGIONS*CNT_W-1:0] err_cnt_o,
  output logic                         err_o,
  output logic [31:0]                  err_addr_o,
  output logic [31:0]                  err_exp_o,
  output logic [31:0]                  err_got_o,
  output logic                         overflow_o,
  output logic                         spurious_ack_o,
  output logic                         done_o
);

  localparam int                SUM_W   = CNT_W + 4;
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  logic                    req;
  logic                    is_wr;
  logic                    req_hit;
  logic [REGION_IDX_W-1:0] req_idx;
  txn_entry_t              push_entry;
  txn_entry_t              head;
  logic                    full;
  logic                    empty;
  logic                    pop;
  logic                    accepted;
  logic                    check_rd;
  logic                    mismatch;
  logic                    count_wr;
  logic [SUM_W-1:0]        rd_sum;
  logic [SUM_W-1:0]        wr_sum;
  logic                    targets_met;

  logic [CNT_W-1:0] rd_cnt  [NUM_REGIONS];
  logic [CNT_W-1:0] wr_cnt  [NUM_REGIONS];
  logic [CNT_W-1:0] err_cnt [NUM_REGIONS];

  assign bus.exp_addr_o = bus.d_addr_i;

  assign is_wr = (bus.d_wr_i != 4'h0);
  assign req   = bus.d_rd_i || is_wr;

  // Walk from the highest region down so the lowest matching index wins on overlap.
  always_comb begin
    req_hit = 1'b0;
    req_idx = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (bus.d_addr_i >= REGION_BASE[(NUM_REGIONS-1-i)*32 +: 32] &&
          bus.d_addr_i <= REGION_LAST[(NUM_REGIONS-1-i)*32 +: 32]) begin
        req_hit = 1'b1;
        req_idx = REGION_IDX_W'(i);
      end
    end
  end

  always_comb begin
    push_entry            = '0;
    push_entry.kind       = is_wr ? KIND_WR : KIND_RD;
    push_entry.hit        = req_hit;
    push_entry.region_idx = req_idx;
    push_entry.addr       = bus.d_addr_i;
    push_entry.exp        = bus.exp_data_i;
  end

  mmio_txn_checker_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (req),
    .push_data (push_entry),
    .pop       (bus.d_ack_i),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  assign pop      = bus.d_ack_i && !empty;
  assign accepted = req && (!full || pop);
  assign check_rd = pop && (head.kind == KIND_RD) && head.hit;
  assign mismatch = (bus.d_data_rd_i != head.exp);
  // A write dropped on overflow is not tracked, so it is not counted either.
  assign count_wr = accepted && is_wr && req_hit;

  always_comb begin
    rd_sum    = '0;
    wr_sum    = '0;
    rd_cnt_o  = '0;
    wr_cnt_o  = '0;
    err_cnt_o = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      rd_sum = rd_sum + SUM_W'(rd_cnt[i]);
      wr_sum = wr_sum + SUM_W'(wr_cnt[i]);
      rd_cnt_o[i*CNT_W +: CNT_W]  = rd_cnt[i];
      wr_cnt_o[i*CNT_W +: CNT_W]  = wr_cnt[i];
      err_cnt_o[i*CNT_W +: CNT_W] = err_cnt[i];
    end
    targets_met = ((TARGET_READS == 0)  || (64'(rd_sum) >= 64'(TARGET_READS))) &&
                  ((TARGET_WRITES == 0) || (64'(wr_sum) >= 64'(TARGET_WRITES)));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        rd_cnt[i]  <= '0;
        wr_cnt[i]  <= '0;
        err_cnt[i] <= '0;
      end
      err_o          <= 1'b0;
      err_addr_o     <= '0;
      err_exp_o      <= '0;
      err_got_o      <= '0;
      overflow_o     <= 1'b0;
      spurious_ack_o <= 1'b0;
      done_o         <= 1'b0;
    end else begin
      err_o <= 1'b0;
      if (bus.d_ack_i && empty)  spurious_ack_o <= 1'b1;
      if (req && full && !pop)   overflow_o     <= 1'b1;
      if (targets_met)           done_o         <= 1'b1;
      if (check_rd && mismatch) begin
        err_o      <= 1'b1;
        err_addr_o <= head.addr;
        err_exp_o  <= head.exp;
        err_got_o  <= bus.d_data_rd_i;
      end
      for (int i = 0; i < NUM_REGIONS; i++) begin
        if (check_rd && head.region_idx == REGION_IDX_W'(i) && rd_cnt[i] != CNT_MAX)
          rd_cnt[i] <= rd_cnt[i] + 1'b1;
        if (check_rd && mismatch && head.region_idx == REGION_IDX_W'(i) && err_cnt[i] != CNT_MAX)
          err_cnt[i] <= err_cnt[i] + 1'b1;
        if (count_wr && req_idx == REGION_IDX_W'(i) && wr_cnt[i] != CNT_MAX)
          wr_cnt[i] <= wr_cnt[i] + 1'b1;
      end
    end
  end

endmodule
